i2c_master_arb: RTL
===================

// Module: i2c_master_arb
// PURPOSE
// Round-robin arbiter sharing one i2c_master command/data interface between PORTS requesters
// (e.g. XFCP I2C module plus on-chip sequencers). A grant covers a whole I2C transaction,
// from first command to the command carrying stop, so START/repeated-START/STOP sequences never interleave.
// A hold timeout injects a stop command if an owner stalls with the bus held.
// PARAMETERS
// PORTS          2      number of requesters, 1..16
// HOLD_TIMEOUT   65535  idle cycles (no cmd accepted, i2c_busy=0) before forced stop; 0 disables
// PORTS
// clk                  in   1        clock
// rst_n                in   1        asynchronous active-low reset
// s_cmd_address        in   PORTS*7  per-port 7-bit address, port i at [i*7+:7]
// s_cmd_start/read/write/write_multiple/stop  in  PORTS each  per-port command flags
// s_cmd_valid          in   PORTS    per-port command valid; also the request line
// s_cmd_ready          out  PORTS    per-port command ready
// s_wr_tdata           in   PORTS*8  per-port write data
// s_wr_tvalid/tlast    in   PORTS    per-port write valid/last
// s_wr_tready          out  PORTS    per-port write ready
// m_rd_tdata/tlast     out  8/1      read data to requesters (shared bus)
// m_rd_tvalid          out  PORTS    read valid, only owner's bit may be set
// m_rd_tready          in   PORTS    per-port read ready
// m_cmd_*              out  7/1..    command to i2c_master (address, flags, valid); m_cmd_ready in
// m_wr_tdata/tvalid/tlast out 8/1/1  write data to i2c_master; m_wr_tready in
// s_rd_tdata/tvalid/tlast in 8/1/1   read data from i2c_master; s_rd_tready out
// i2c_busy             in   1        i2c_master busy flag
// grant                out  PORTS    one-hot owner, 0 when IDLE
// timeout_event        out  1        one-cycle pulse when a forced stop is accepted
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE, grant=0, rr pointer=0, all valid/ready outputs 0, timer=0.
//   Reset mid-transaction abandons it; i2c_master must share the reset.
// - States: IDLE -> OWN -> DRAIN -> IDLE; FORCE entered from OWN on timeout.
// - IDLE: any s_cmd_valid set -> next cycle OWN, grant = first requester at or after rr pointer
//   (wrap modulo PORTS). Grant latency exactly 1 cycle; no ready asserted in IDLE.
//   s_rd_tready=1 in IDLE (stray read bytes discarded).
// - OWN: owner's cmd/wr/rd channels combinationally muxed to master; non-owners see ready=0,
//   m_rd_tvalid bit 0. Command handshake = m_cmd_valid & m_cmd_ready.
//   Command with stop=1 accepted -> DRAIN. rr pointer = owner+1 (wrap) on entry to DRAIN or FORCE.
// - Timer: in OWN, increments while no cmd accepted and i2c_busy=0; clears on any accepted cmd.
//   At timer==HOLD_TIMEOUT-1 -> FORCE. Saturates, never wraps.
// - FORCE: owner's s_cmd_ready=0; arbiter drives m_cmd_valid=1, stop=1, other flags/address 0
//   until accepted; on accept pulse timeout_event, go DRAIN.
// - DRAIN: read data still routed to owner; waits i2c_busy=0 and no s_rd_tvalid pending,
//   then -> IDLE, grant=0. New requests ignored until IDLE; a request in IDLE is granted next cycle.
// - Owner dropping s_cmd_valid does not release grant; only stop or timeout releases it.
// - m_cmd_valid never deasserts before ready once raised (AXI-stream rule, held from owner).
// - PORTS=1: rr pointer constant 0, behaviour otherwise identical.
// TESTING
// - Ports 0,1 request same cycle after reset -> grant=01 next cycle; port1 ready=0 until port0 stop accepted and i2c_busy falls.
// - Port0 write(addr 0x50, 2 bytes, stop) then both request -> port1 granted (rr), then port0.
// - Port1 start+read 3 bytes, stop -> 3 bytes appear only on m_rd_tvalid[1]; m_rd_tvalid[0] stays 0.
// - HOLD_TIMEOUT=16, port0 issues start+write without stop then idles -> after 16 idle cycles forced stop on m_cmd, timeout_event pulses 1 cycle, grant=0.
// - Assert rst_n low in OWN with m_cmd_valid high -> all outputs 0 immediately (async), grant=0.
// - Owner's m_cmd_valid held with m_cmd_ready=0 for 10 cycles -> address/flags stable, no other port served.

Source files
------------

// File: rtl/i2c_master_arb_if.sv
// Bus bundle between the requesters, the arbiter and the shared i2c_master.
// The master modport is the arbiter's view; slave is the environment's view.
interface i2c_master_arb_if #(
  parameter int PORTS = 2
);
  logic [PORTS*7-1:0] s_cmd_address;
  logic [PORTS-1:0]   s_cmd_start;
  logic [PORTS-1:0]   s_cmd_read;
  logic [PORTS-1:0]   s_cmd_write;
  logic [PORTS-1:0]   s_cmd_write_multiple;
  logic [PORTS-1:0]   s_cmd_stop;
  logic [PORTS-1:0]   s_cmd_valid;
  logic [PORTS-1:0]   s_cmd_ready;

  logic [PORTS*8-1:0] s_wr_tdata;
  logic [PORTS-1:0]   s_wr_tvalid;
  logic [PORTS-1:0]   s_wr_tlast;
  logic [PORTS-1:0]   s_wr_tready;

  logic [7:0]         m_rd_tdata;
  logic               m_rd_tlast;
  logic [PORTS-1:0]   m_rd_tvalid;
  logic [PORTS-1:0]   m_rd_tready;

  logic [6:0]         m_cmd_address;
  logic               m_cmd_start;
  logic               m_cmd_read;
  logic               m_cmd_write;
  logic               m_cmd_write_multiple;
  logic               m_cmd_stop;
  logic               m_cmd_valid;
  logic               m_cmd_ready;

  logic [7:0]         m_wr_tdata;
  logic               m_wr_tvalid;
  logic               m_wr_tlast;
  logic               m_wr_tready;

  logic [7:0]         s_rd_tdata;
  logic               s_rd_tvalid;
  logic               s_rd_tlast;
  logic               s_rd_tready;

  logic               i2c_busy;
  logic [PORTS-1:0]   grant;
  logic               timeout_event;

  modport master (
    input  s_cmd_address, s_cmd_start, s_cmd_read, s_cmd_write, s_cmd_write_multiple,
           s_cmd_stop, s_cmd_valid, s_wr_tdata, s_wr_tvalid, s_wr_tlast, m_rd_tready,
           m_cmd_ready, m_wr_tready, s_rd_tdata, s_rd_tvalid, s_rd_tlast, i2c_busy,
    output s_cmd_ready, s_wr_tready, m_rd_tdata, m_rd_tlast, m_rd_tvalid,
           m_cmd_address, m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple,
           m_cmd_stop, m_cmd_valid, m_wr_tdata, m_wr_tvalid, m_wr_tlast, s_rd_tready,
           grant, timeout_event
  );

  modport slave (
    output s_cmd_address, s_cmd_start, s_cmd_read, s_cmd_write, s_cmd_write_multiple,
           s_cmd_stop, s_cmd_valid, s_wr_tdata, s_wr_tvalid, s_wr_tlast, m_rd_tready,
           m_cmd_ready, m_wr_tready, s_rd_tdata, s_rd_tvalid, s_rd_tlast, i2c_busy,
    input  s_cmd_ready, s_wr_tready, m_rd_tdata, m_rd_tlast, m_rd_tvalid,
           m_cmd_address, m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple,
           m_cmd_stop, m_cmd_valid, m_wr_tdata, m_wr_tvalid, m_wr_tlast, s_rd_tready,
           grant, timeout_event
  );
endinterface

// File: rtl/i2c_master_arb.sv
// Round-robin arbiter sharing one i2c_master between PORTS requesters.
// A grant spans a whole I2C transaction (first command up to the command
// carrying stop) so START/STOP sequences from different owners never mix.
//
// state | meaning
// IDLE  | no owner; stray read bytes are sunk; any request is granted next cycle
// OWN   | owner's cmd/wr/rd channels routed to the master; hold timer running
// FORCE | owner stalled with the bus held; arbiter issues a bare stop command
// DRAIN | stop accepted; wr/rd still routed to owner until master goes idle
module i2c_master_arb #(
  parameter int PORTS        = 2,
  parameter int HOLD_TIMEOUT = 65535
) (
  input logic            clk,
  input logic            rst_n,
  i2c_master_arb_if.master bus
);
  localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int TW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam logic [TW-1:0] TLIM = TW'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);
  localparam bit TIMEOUT_EN = (HOLD_TIMEOUT > 0);

  typedef enum logic [1:0] {IDLE, OWN, FORCE, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [IW-1:0] rr_ptr, rr_nxt;
  logic [IW-1:0] rr_after;
  logic [IW-1:0] pick;
  logic          pick_found;
  logic [TW-1:0] timer, timer_nxt;
  logic          cmd_fire;
  logic          wr_route;
  logic          rd_route;

  assign cmd_fire = bus.m_cmd_valid & bus.m_cmd_ready;
  assign rr_after = IW'((int'(owner) + 1) % PORTS);

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int k = 0; k < PORTS; k++) begin
      if (!pick_found && bus.s_cmd_valid[(int'(rr_ptr) + k) % PORTS]) begin
        pick       = IW'((int'(rr_ptr) + k) % PORTS);
        pick_found = 1'b1;
      end
    end
  end

  // State, owner, pointer and hold timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      timer  <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_nxt;
      timer  <= timer_nxt;
    end
  end

  // Next-state logic. The forced stop is only launched while the owner is not
  // presenting a command, so a raised m_cmd_valid is never withdrawn.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    timer_nxt = timer;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (pick_found) begin
          state_nxt = OWN;
          owner_nxt = pick;
        end
      end
      OWN: begin
        if (cmd_fire) begin
          timer_nxt = '0;
          if (bus.m_cmd_stop) begin
            state_nxt = DRAIN;
            rr_nxt    = rr_after;
          end
        end else if (!bus.i2c_busy) begin
          if (timer != TLIM) begin
            timer_nxt = timer + 1'b1;
          end else if (TIMEOUT_EN && !bus.m_cmd_valid) begin
            state_nxt = FORCE;
            rr_nxt    = rr_after;
          end
        end
      end
      FORCE: begin
        timer_nxt = '0;
        if (bus.m_cmd_ready) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!bus.i2c_busy && !bus.s_rd_tvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Channel muxing between the owner and the shared master.
  always_comb begin
    bus.m_cmd_address        = '0;
    bus.m_cmd_start          = 1'b0;
    bus.m_cmd_read           = 1'b0;
    bus.m_cmd_write          = 1'b0;
    bus.m_cmd_write_multiple = 1'b0;
    bus.m_cmd_stop           = 1'b0;
    bus.m_cmd_valid          = 1'b0;
    bus.s_cmd_ready          = '0;
    bus.m_wr_tdata           = '0;
    bus.m_wr_tvalid          = 1'b0;
    bus.m_wr_tlast           = 1'b0;
    bus.s_wr_tready          = '0;
    bus.m_rd_tdata           = bus.s_rd_tdata;
    bus.m_rd_tlast           = bus.s_rd_tlast;
    bus.m_rd_tvalid          = '0;
    bus.s_rd_tready          = 1'b0;
    bus.timeout_event        = 1'b0;
    wr_route                 = 1'b0;
    rd_route                 = 1'b0;
    case (state)
      IDLE: bus.s_rd_tready = rst_n;
      OWN: begin
        bus.m_cmd_address        = bus.s_cmd_address[int'(owner)*7 +: 7];
        bus.m_cmd_start          = bus.s_cmd_start[owner];
        bus.m_cmd_read           = bus.s_cmd_read[owner];
        bus.m_cmd_write          = bus.s_cmd_write[owner];
        bus.m_cmd_write_multiple = bus.s_cmd_write_multiple[owner];
        bus.m_cmd_stop           = bus.s_cmd_stop[owner];
        bus.m_cmd_valid          = bus.s_cmd_valid[owner];
        bus.s_cmd_ready[owner]   = bus.m_cmd_ready;
        wr_route                 = 1'b1;
        rd_route                 = 1'b1;
      end
      FORCE: begin
        bus.m_cmd_stop    = 1'b1;
        bus.m_cmd_valid   = 1'b1;
        bus.timeout_event = bus.m_cmd_ready;
        rd_route          = 1'b1;
      end
      DRAIN: begin
        wr_route = 1'b1;
        rd_route = 1'b1;
      end
      default: ;
    endcase
    if (wr_route) begin
      bus.m_wr_tdata         = bus.s_wr_tdata[int'(owner)*8 +: 8];
      bus.m_wr_tvalid        = bus.s_wr_tvalid[owner];
      bus.m_wr_tlast         = bus.s_wr_tlast[owner];
      bus.s_wr_tready[owner] = bus.m_wr_tready;
    end
    if (rd_route) begin
      bus.m_rd_tvalid[owner] = bus.s_rd_tvalid;
      bus.s_rd_tready        = bus.m_rd_tready[owner];
    end
  end

  // One-hot owner, zero while no one holds the bus.
  always_comb begin
    bus.grant = '0;
    if (state != IDLE) bus.grant[owner] = 1'b1;
  end
endmodule
